bp_fe_bht_update_queue: RTL and testbench

BP_FE_BHT_UPDATE_QUEUE -- requirements
Module: bp_fe_bht_update_queue

---
 rtl/bp_fe_bht_update_queue.sv | 125 ++++++++++++
 tb/tb_bp_fe_bht_update_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_bht_update_queue.sv
// In-order queue of issued branch predictions that turns resolutions into BHT update writes.
// Define BP_FE_BHT_UPDQ_STATS_EN to add saturating resolve/mispredict counters.
module bp_fe_bht_update_queue
  #(parameter bht_idx_width_p = "inv"
  , parameter els_p           = 8
  )
  (input  logic                         clk_i
  , input  logic                        reset_i

  , input  logic                        pred_v_i
  , input  logic [bht_idx_width_p-1:0]  pred_idx_i
  , input  logic                        pred_taken_i
  , output logic                        pred_ready_o

  , input  logic                        resolve_v_i
  , input  logic                        resolve_taken_i
  , output logic                        resolve_ready_o

  , input  logic                        flush_i

  , output logic                        w_v_o
  , output logic [bht_idx_width_p-1:0]  idx_w_o
  , output logic                        correct_o
  , output logic [$clog2(els_p+1)-1:0]  count_o
`ifdef BP_FE_BHT_UPDQ_STATS_EN
  , output logic [15:0]                 mispredict_cnt_o
  , output logic [15:0]                 resolve_cnt_o
`endif
  );

  localparam int lg_els_lp = $clog2(els_p);
  localparam int ptr_w_lp  = lg_els_lp + 1;
  localparam int cnt_w_lp  = $clog2(els_p+1);

  logic [ptr_w_lp-1:0]        wptr, rptr;
  logic [bht_idx_width_p-1:0] idx_mem   [els_p];
  logic                       taken_mem [els_p];

  logic empty, full, enq, deq;
  logic head_taken;
  logic [bht_idx_width_p-1:0] head_idx;

  // Extra pointer bit distinguishes full from empty when the low bits match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[lg_els_lp-1:0] == rptr[lg_els_lp-1:0])
               & (wptr[lg_els_lp] != rptr[lg_els_lp]);

  assign pred_ready_o    = ~full;
  assign resolve_ready_o = ~empty;
  assign count_o         = cnt_w_lp'(wptr - rptr);

  assign enq = pred_v_i    & ~full  & ~flush_i;
  assign deq = resolve_v_i & ~empty & ~flush_i;

  assign head_idx   = idx_mem[rptr[lg_els_lp-1:0]];
  assign head_taken = taken_mem[rptr[lg_els_lp-1:0]];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (enq) wptr <= wptr + ptr_w_lp'(1);
      if (deq) rptr <= rptr + ptr_w_lp'(1);
    end
  end

  // Stage p0 -> storage: entries are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      idx_mem[wptr[lg_els_lp-1:0]]   <= pred_idx_i;
      taken_mem[wptr[lg_els_lp-1:0]] <= pred_taken_i;
    end
  end

  logic                       w_v_p1;
  logic [bht_idx_width_p-1:0] idx_w_p1;
  logic                       correct_p1;

  // Stage p1: registered BHT update, one cycle after the dequeue.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      w_v_p1     <= 1'b0;
      idx_w_p1   <= '0;
      correct_p1 <= 1'b0;
    end else begin
      w_v_p1 <= deq;
      if (deq) begin
        idx_w_p1   <= head_idx;
        correct_p1 <= (head_taken == resolve_taken_i);
      end
    end
  end

  assign w_v_o     = w_v_p1;
  assign idx_w_o   = idx_w_p1;
  assign correct_o = correct_p1;

`ifdef BP_FE_BHT_UPDQ_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] mispredict_cnt_p1, resolve_cnt_p1;

  // Counters survive flushes; only reset clears them.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mispredict_cnt_p1 <= '0;
      resolve_cnt_p1    <= '0;
    end else if (deq) begin
      resolve_cnt_p1 <= sat_inc(resolve_cnt_p1);
      if (head_taken != resolve_taken_i)
        mispredict_cnt_p1 <= sat_inc(mispredict_cnt_p1);
    end
  end

  assign mispredict_cnt_o = mispredict_cnt_p1;
  assign resolve_cnt_o    = resolve_cnt_p1;
`endif

endmodule

// File: tb/tb_bp_fe_bht_update_queue.sv
// Scoreboard bench for bp_fe_bht_update_queue (els_p=8, 4-bit index).
module tb_bp_fe_bht_update_queue;

  localparam int IDX_W = 4;
  localparam int ELS   = 8;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             pred_v_i, pred_taken_i, pred_ready_o;
  logic [IDX_W-1:0] pred_idx_i;
  logic             resolve_v_i, resolve_taken_i, resolve_ready_o;
  logic             flush_i;
  logic             w_v_o, correct_o;
  logic [IDX_W-1:0] idx_w_o;
  logic [3:0]       count_o;
`ifdef BP_FE_BHT_UPDQ_STATS_EN
  logic [15:0]      mispredict_cnt_o, resolve_cnt_o;
`endif

  bp_fe_bht_update_queue #(.bht_idx_width_p(IDX_W), .els_p(ELS)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .pred_v_i(pred_v_i), .pred_idx_i(pred_idx_i), .pred_taken_i(pred_taken_i),
    .pred_ready_o(pred_ready_o),
    .resolve_v_i(resolve_v_i), .resolve_taken_i(resolve_taken_i),
    .resolve_ready_o(resolve_ready_o),
    .flush_i(flush_i),
    .w_v_o(w_v_o), .idx_w_o(idx_w_o), .correct_o(correct_o), .count_o(count_o)
`ifdef BP_FE_BHT_UPDQ_STATS_EN
    , .mispredict_cnt_o(mispredict_cnt_o), .resolve_cnt_o(resolve_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  logic [IDX_W:0] mq[$];     // model FIFO: {idx, taken}
  logic [IDX_W:0] exp_q[$];  // expected updates: {idx, correct}
  logic [IDX_W-1:0] exp_idx;
  logic             exp_corr;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    exp_idx  = '0;
    exp_corr = 1'b0;
  endtask

  // Drive one cycle of stimulus, update the model, then check after the edge.
  task automatic step(input bit pv, input logic [IDX_W-1:0] pidx, input bit pt,
                      input bit rv, input bit rt, input bit fl);
    bit enq, deq;
    logic [IDX_W:0] e;
    pred_v_i = pv; pred_idx_i = pidx; pred_taken_i = pt;
    resolve_v_i = rv; resolve_taken_i = rt; flush_i = fl;
    enq = pv && (mq.size() < ELS) && !fl;
    deq = rv && (mq.size() > 0) && !fl;
    if (deq) begin
      e = mq.pop_front();
      exp_q.push_back({e[IDX_W:1], e[0] == rt});
    end
    if (fl) mq.delete();
    if (enq) mq.push_back({pidx, pt});
    @(posedge clk_i); #1;
    pred_v_i = 1'b0; resolve_v_i = 1'b0; flush_i = 1'b0;
    chk("w_v", 32'(w_v_o), 32'(deq));
    if (deq && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      exp_idx  = e[IDX_W:1];
      exp_corr = e[0];
    end
    chk("idx_w", 32'(idx_w_o), 32'(exp_idx));
    chk("correct", 32'(correct_o), 32'(exp_corr));
    chk("count", 32'(count_o), 32'(mq.size()));
    chk("pred_ready", 32'(pred_ready_o), 32'(mq.size() < ELS));
    chk("resolve_ready", 32'(resolve_ready_o), 32'(mq.size() > 0));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_w_v"}, 32'(w_v_o), 0);
    chk({tag, "_idx_w"}, 32'(idx_w_o), 0);
    chk({tag, "_correct"}, 32'(correct_o), 0);
    chk({tag, "_count"}, 32'(count_o), 0);
    chk({tag, "_pred_ready"}, 32'(pred_ready_o), 1);
    chk({tag, "_resolve_ready"}, 32'(resolve_ready_o), 0);
  endtask

  task automatic fill_to(input int n);
    while (mq.size() < n) step(1, 4'($urandom_range(15)), 1'($urandom_range(1)), 0, 0, 0);
    while (mq.size() > n) step(0, 0, 0, 1, 1'($urandom_range(1)), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1;
    pred_v_i = 0; pred_idx_i = 0; pred_taken_i = 0;
    resolve_v_i = 0; resolve_taken_i = 0; flush_i = 0;
    model_reset();
    #12;
    check_reset_vals("rst0");
    @(posedge clk_i); #1;
    reset_i = 1'b0;

    // Basic round trip: predicted taken, resolved not taken.
    step(1, 4'd5, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("rt_w_v", 32'(w_v_o), 1);
    chk("rt_idx", 32'(idx_w_o), 5);
    chk("rt_correct", 32'(correct_o), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rt_w_v_off", 32'(w_v_o), 0);

    // Fill, overflow drop, drain in order, then wrap.
    for (int i = 0; i < ELS; i++) step(1, 4'(i + 1), 1'(i), 0, 0, 0);
    chk("full_count", 32'(count_o), 8);
    chk("full_ready", 32'(pred_ready_o), 0);
    step(1, 4'd15, 1, 0, 0, 0);
    for (int i = 0; i < ELS; i++) begin
      step(0, 0, 0, 1, 1, 0);
      chk("drain_order", 32'(idx_w_o), 32'(i + 1));
    end
    step(1, 4'd3, 0, 0, 0, 0);
    for (int i = 0; i < ELS; i++) step(1, 4'(i + 7), 1'(i >> 1), 1, 1'($urandom_range(1)), 0);
    step(0, 0, 0, 1, 0, 0);

    // Simultaneous operations at count 3, 0 and 8.
    fill_to(3);
    step(1, 4'd9, 1, 1, 1, 0);
    chk("sim3_count", 32'(count_o), 3);
    fill_to(0);
    step(1, 4'd6, 0, 1, 0, 0);
    chk("sim0_count", 32'(count_o), 1);
    fill_to(8);
    step(1, 4'd2, 1, 1, 0, 0);
    chk("sim8_count", 32'(count_o), 7);

    // Flush at count 5 right after an update was registered.
    fill_to(6);
    step(0, 0, 0, 1, 1, 0);
    step(1, 4'd4, 1, 1, 1, 1);
    chk("flush_count", 32'(count_o), 0);
    chk("flush_w_v", 32'(w_v_o), 0);

    // Random traffic.
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(1)), 4'($urandom_range(15)), 1'($urandom_range(1)),
           1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(19) == 0));

    // Asynchronous reset mid-stream at count 4 with an update on the outputs.
    fill_to(5);
    step(0, 0, 0, 1, 0, 0);
    chk("pre_rst_count", 32'(count_o), 4);
    #3 reset_i = 1'b1;
    #1 check_reset_vals("rst1");
    model_reset();
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    step(0, 0, 0, 1, 1, 0);
    chk("post_rst_w_v", 32'(w_v_o), 0);

`ifdef BP_FE_BHT_UPDQ_STATS_EN
    for (int i = 0; i < 5; i++) step(1, 4'(i), 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, (i < 3), 0);
    chk("resolve_cnt", 32'(resolve_cnt_o), 5);
    chk("mispredict_cnt", 32'(mispredict_cnt_o), 2);
    step(1, 4'd1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1);
    chk("resolve_cnt_flush", 32'(resolve_cnt_o), 5);
    chk("mispredict_cnt_flush", 32'(mispredict_cnt_o), 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
